// File: rtl/mux_n_to_1_rr.sv
// mux_n_to_1_rr: N-to-1 word selector, explicit or round-robin grant, one-entry valid/ready output register
module mux_n_to_1_rr #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int SEL_W = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mode,
  input  logic [SEL_W-1:0]   sel,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [SEL_W-1:0]   out_sel,
  output logic               out_valid,
  input  logic               out_ready
);
  logic [SEL_W-1:0] r_ptr;
  logic [SEL_W-1:0] w_rr;
  logic [SEL_W-1:0] w_grant;
  logic             w_gv;
  logic             w_load;
  logic             w_sel_ok;
  always_comb begin
    w_rr = '0;
    // walk from the farthest candidate back so the nearest one after r_ptr wins
    for (int k = N; k >= 1; k--)
      if (in_valid[(int'(r_ptr) + k) % N]) w_rr = SEL_W'((int'(r_ptr) + k) % N);
    w_sel_ok = int'(sel) < N;
    w_grant  = mode ? w_rr : sel;
    w_gv     = mode ? |in_valid : (w_sel_ok && in_valid[sel]);
    w_load   = !out_valid || out_ready;
    in_ready = (!rst && w_load && w_gv) ? ({{(N-1){1'b0}}, 1'b1} << w_grant) : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      r_ptr     <= SEL_W'(N - 1);
    end else if (w_load) begin
      out_valid <= w_gv;
      if (w_gv) begin
        out_data <= in_data[int'(w_grant)*WIDTH +: WIDTH];
        out_sel  <= w_grant;
        if (mode) r_ptr <= w_grant;
      end
    end
  end
endmodule

// File: tb/tb_mux_n_to_1_rr.sv
// tb_mux_n_to_1_rr: directed scenarios plus randomized traffic against a behavioural selector model
module tb_mux_n_to_1_rr;
  localparam int WIDTH = 32;
  localparam int N     = 4;
  localparam int SEL_W = 2;
  logic               clk = 0;
  logic               rst = 1;
  logic               mode = 1;
  logic [SEL_W-1:0]   sel = '0;
  logic [N*WIDTH-1:0] in_data = '0;
  logic [N-1:0]       in_valid = '0;
  logic [N-1:0]       in_ready;
  logic [WIDTH-1:0]   out_data;
  logic [SEL_W-1:0]   out_sel;
  logic               out_valid;
  logic               out_ready = 1;
  int n_checks = 0;
  int n_err = 0;
  bit m_init = 0;
  bit m_valid;
  logic [WIDTH-1:0] m_data;
  int m_sel, m_ptr;
  mux_n_to_1_rr #(.WIDTH(WIDTH), .N(N)) dut (
    .clk(clk), .rst(rst), .mode(mode), .sel(sel), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_sel(out_sel), .out_valid(out_valid),
    .out_ready(out_ready)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    n_checks++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask
  function automatic int f_grant();
    if (!mode) return (int'(sel) < N && in_valid[sel]) ? int'(sel) : -1;
    for (int k = 1; k <= N; k++) if (in_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction
  function automatic logic [N-1:0] f_ready();
    int g;
    g = f_grant();
    if (rst || m_valid && !out_ready || g < 0) return '0;
    return N'(1 << g);
  endfunction
  always @(posedge clk) begin
    int g;
    if (rst) begin
      m_init = 1; m_valid = 0; m_data = '0; m_sel = 0; m_ptr = N - 1;
    end else if (m_init && (!m_valid || out_ready)) begin
      g = f_grant();
      if (g >= 0) begin
        m_valid = 1; m_data = in_data[g*WIDTH +: WIDTH]; m_sel = g;
        if (mode) m_ptr = g;
      end else m_valid = 0;
    end
  end
  always @(negedge clk) if (m_init) begin
    chk("model in_ready", 64'(in_ready), 64'(f_ready()));
    chk("model out_valid", 64'(out_valid), 64'(m_valid));
    chk("model out_data", 64'(out_data), 64'(m_data));
    chk("model out_sel", 64'(out_sel), 64'(m_sel));
  end
  task automatic cyc();
    @(posedge clk); #1;
  endtask
  task automatic neg();
    @(negedge clk);
  endtask
  task automatic rr_data();
    for (int i = 0; i < N; i++) in_data[i*WIDTH +: WIDTH] = WIDTH'(i + 1);
  endtask
  initial begin
    rst = 1; mode = 1; in_valid = 4'b1111; out_ready = 1; rr_data();
    cyc(); neg();
    chk("rst in_ready", 64'(in_ready), 0);
    chk("rst out_valid", 64'(out_valid), 0);
    chk("rst out_data", 64'(out_data), 0);
    chk("rst out_sel", 64'(out_sel), 0);
    cyc(); rst = 0; neg();
    chk("post-rst in_ready", 64'(in_ready), 64'h1);
    mode = 0; sel = 2; in_valid = 4'b0100; in_data[2*WIDTH +: WIDTH] = 32'hDEADBEEF; neg();
    chk("sel2 in_ready", 64'(in_ready), 64'h4);
    cyc(); sel = 1; in_valid = 4'b0000; neg();
    chk("sel2 out_data", 64'(out_data), 64'hDEADBEEF);
    chk("sel2 out_sel", 64'(out_sel), 2);
    chk("sel2 out_valid", 64'(out_valid), 1);
    chk("sel1 idle in_ready", 64'(in_ready), 0);
    cyc(); neg();
    chk("sel1 idle out_valid", 64'(out_valid), 0);
    rst = 1; cyc(); rst = 0;
    mode = 1; in_valid = 4'b1111; rr_data();
    for (int k = 0; k < 8; k++) begin
      cyc(); neg();
      chk("rr out_data", 64'(out_data), 64'((k % 4) + 1));
      chk("rr out_sel", 64'(out_sel), 64'(k % 4));
    end
    rst = 1; cyc(); rst = 0; neg();
    chk("midrst out_valid", 64'(out_valid), 0);
    cyc(); neg();
    chk("midrst restart data", 64'(out_data), 1);
    in_valid = 4'b1001;
    cyc(); neg();
    chk("skip ch3 sel", 64'(out_sel), 3);
    chk("skip ch3 data", 64'(out_data), 4);
    cyc(); neg();
    chk("skip ch0 sel", 64'(out_sel), 0);
    mode = 0; sel = 0; in_valid = 4'b0001; in_data[0 +: WIDTH] = 32'hA5A5A5A5;
    cyc(); out_ready = 0; mode = 1; in_valid = 4'b0010; in_data[WIDTH +: WIDTH] = 32'h11111111;
    for (int k = 0; k < 3; k++) begin
      neg();
      chk("stall out_data", 64'(out_data), 64'hA5A5A5A5);
      chk("stall in_ready", 64'(in_ready), 0);
      cyc();
    end
    out_ready = 1; neg();
    chk("unstall in_ready", 64'(in_ready), 64'h2);
    cyc(); neg();
    chk("unstall out_data", 64'(out_data), 64'h11111111);
    chk("unstall out_sel", 64'(out_sel), 1);
    for (int k = 0; k < 3000; k++) begin
      cyc();
      rst = ($urandom_range(0, 99) == 0);
      mode = ($urandom_range(0, 3) != 0);
      sel = SEL_W'($urandom);
      in_valid = N'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) in_data[i*WIDTH +: WIDTH] = $urandom;
    end
    cyc(); neg();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule

// File: doc/mux_n_to_1_rr.md
# mux_n_to_1_rr

Parametrised N-channel, WIDTH-bit selector with a registered, valid/ready-handshaked output stage. It generalises the CPU's combinational 2:1 word mux. It supports explicit select and round-robin arbitration, so several requesters (e.g. fetch, load/store, debug) can share one downstream port. It sits between requesters and a single consumer such as the memory port or the writeback bus.

## Interface
Parameters:
- WIDTH, 32, data width per channel
- N, 4, number of input channels (N >= 2)
- SEL_W, $clog2(N), width of select/grant index

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- mode  input  1  0 = explicit select via sel, 1 = round-robin arbitration
- sel  input  SEL_W  channel index used when mode = 0
- in_data  input  N*WIDTH  channel i data at bits [i*WIDTH +: WIDTH]
- in_valid  input  N  per-channel request
- in_ready  output  N  per-channel accept; combinational, at most one bit set
- out_data  output  WIDTH  registered selected word
- out_sel  output  SEL_W  registered index of the channel that supplied out_data
- out_valid  output  1  registered, out_data holds an unconsumed word
- out_ready  input  1  consumer accepts out_data this cycle

## Operation
- load_en = !out_valid || out_ready. This is a one-entry pipeline register with full throughput.
- Grant, combinational:
  - mode 0: grant = sel, grant_valid = in_valid[sel] && (sel < N). An out-of-range sel gives no grant.
  - mode 1: search channels ptr+1, ptr+2, … modulo N. Grant goes to the first with in_valid set. grant_valid = |in_valid.
- in_ready[i] = load_en && grant_valid && (grant == i). Other channels see 0.
- Transfer on channel i occurs when in_valid[i] && in_ready[i].
- On a transfer: out_data <= in_data[grant], out_sel <= grant, out_valid <= 1.
- When load_en && !grant_valid: out_valid <= 0. out_data and out_sel hold their values.
- When !load_en (stall): out_data, out_sel and out_valid hold.
- Round-robin pointer ptr (SEL_W bits):
  - ptr <= grant only on a transfer while mode = 1.
  - ptr is untouched in mode 0.
  - Switching mode never resets ptr.
- Requesters must hold in_valid and in_data until accepted. The block does not require this, but data is sampled only on transfer.

## Timing
- Reset, applied at a clock edge: out_valid = 0, out_data = 0, out_sel = 0, ptr = N-1, so channel 0 has first priority after reset.
- Reset has priority over any simultaneous transfer. A word in flight is discarded and no in_ready is honoured that cycle; in_ready is forced to 0 while rst = 1.
- Latency: input accepted at edge k is visible on out_data/out_valid after edge k.
- Throughput: one word per cycle when out_ready is held high.
- Simultaneous consume and load: with out_valid = 1 and out_ready = 1, the new word replaces the old in the same edge. There is no bubble.
- Stall: out_valid = 1 and out_ready = 0 forces all in_ready = 0. out_* stay stable until consumed.
- Fairness: in mode 1 with all N channels continuously valid and out_ready = 1, grants cycle 0,1,…,N-1,0,… Each channel waits at most N-1 transfers.
- Wrap-around: ptr = N-1 searches from channel 0. For N not a power of two, the modulo-N search never visits indices >= N.

## Test plan
- Reset: drive rst = 1 for 2 cycles with all in_valid = 1 → out_valid = 0, out_data = 0, out_sel = 0, in_ready = 0. In the first cycle after release (mode 1), in_ready = 4'b0001.
- Explicit select: N = 4, mode 0, sel = 2, in_data ch2 = 32'hDEADBEEF, in_valid = 4'b0100, out_ready = 1 → in_ready = 4'b0100. Next cycle out_data = 32'hDEADBEEF, out_sel = 2, out_valid = 1. With sel = 1 and in_valid[1] = 0: in_ready = 0, and out_valid drops to 0 after one cycle.
- Round-robin fairness: mode 1, in_valid = 4'b1111, channel i data = i+1, out_ready = 1 for 8 cycles → out_data sequence 1,2,3,4,1,2,3,4, out_sel sequence 0,1,2,3,0,1,2,3.
- Skip idle channels: mode 1, ptr = 0 after one grant, in_valid = 4'b1001 → next grant is ch3, then ch0. Channels 1 and 2 never receive in_ready.
- Backpressure: out_valid = 1 holding 32'hA5A5A5A5, out_ready = 0 for 3 cycles while ch1 is valid → out_data stable, in_ready = 0. Raise out_ready → ch1 accepted in that cycle and appears on the next edge with no gap.
- Reset mid-stream: during the round-robin run, assert rst for 1 cycle while out_valid = 1 → out_valid = 0 on the next edge. The sequence restarts at ch0 (out_data = 1).
